// File: rtl/timer_irq_master.sv
// timer_irq_master: Avalon-MM sequencer that programs the interval timer and services its timeouts.
// Optional feature macro: TIMER_IRQ_MASTER_STATUS_CHECK_EN (read status TO before counting a timeout).
module timer_irq_master #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              m_irq,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
    ,
    output logic [7:0]        spurious_count
`endif
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] WR_PL   = 4'd1;
    localparam logic [3:0] WR_PH   = 4'd2;
    localparam logic [3:0] WR_CTL  = 4'd3;
    localparam logic [3:0] ARMED   = 4'd4;
    localparam logic [3:0] WR_CLR  = 4'd7;
    localparam logic [3:0] WR_STOP = 4'd8;
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
    localparam logic [3:0] RD_ST   = 4'd5;
    localparam logic [3:0] RD_WAIT = 4'd6;
    localparam logic [3:0] IRQ_NXT = RD_ST;
    logic unused_rd;
    assign unused_rd = ^m_readdata[15:1];
`else
    localparam logic [3:0] IRQ_NXT = WR_CLR;
    logic unused_rd;
    assign unused_rd = ^m_readdata;
`endif

    logic [3:0]  state, nxt;
    logic [15:0] period_hi;
    logic        cont_q, stop_pending, just_clr;
    logic        acc_cs, acc_wn;
    logic [2:0]  acc_addr;
    logic [15:0] acc_data;

    assign busy = state != IDLE;

    // Next-state decision; an IRQ still high right after a clear is stale and ignored
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cmd_start ? WR_PL : IDLE;
            WR_PL:   nxt = WR_PH;
            WR_PH:   nxt = WR_CTL;
            WR_CTL:  nxt = ARMED;
            ARMED:   nxt = stop_pending ? WR_STOP : (m_irq && !just_clr) ? IRQ_NXT : ARMED;
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
            RD_ST:   nxt = RD_WAIT;
            RD_WAIT: nxt = m_readdata[0] ? WR_CLR : ARMED;
`endif
            WR_CLR:  nxt = stop_pending ? WR_STOP : cont_q ? ARMED : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Bus access belonging to the state being entered, so outputs can be registered
    always_comb begin
        acc_cs   = 1'b1;
        acc_wn   = 1'b0;
        acc_addr = 3'd0;
        acc_data = 16'h0000;
        case (nxt)
            WR_PL:   begin acc_addr = 3'd2; acc_data = cmd_period[15:0]; end
            WR_PH:   begin acc_addr = 3'd3; acc_data = period_hi; end
            WR_CTL:  begin acc_addr = 3'd1; acc_data = {13'd0, 1'b1, cont_q, 1'b1}; end
            WR_CLR:  begin end
            WR_STOP: begin acc_addr = 3'd1; acc_data = 16'h0008; end
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
            RD_ST:   acc_wn = 1'b1;
`endif
            default: begin acc_cs = 1'b0; acc_wn = 1'b1; end
        endcase
    end

    // State, command latches, registered bus outputs and tick counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            period_hi    <= 16'h0000;
            cont_q       <= 1'b0;
            stop_pending <= 1'b0;
            just_clr     <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 3'd0;
            m_writedata  <= 16'h0000;
            tick         <= 1'b0;
            tick_count   <= '0;
        end else begin
            state        <= nxt;
            if (state == IDLE && cmd_start) begin
                period_hi <= cmd_period[31:16];
                cont_q    <= cmd_continuous;
            end
            stop_pending <= (nxt == IDLE) ? 1'b0 : stop_pending | (cmd_stop && busy);
            just_clr     <= state == WR_CLR;
            m_chipselect <= acc_cs;
            m_write_n    <= acc_wn;
            m_address    <= acc_addr;
            m_writedata  <= acc_data;
            tick         <= nxt == WR_CLR;
            if (nxt == WR_CLR)
                tick_count <= tick_count + 1'b1;
        end
    end

`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
    // Count IRQs whose status read shows no timeout, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            spurious_count <= 8'h00;
        else if (state == RD_WAIT && !m_readdata[0] && spurious_count != 8'hFF)
            spurious_count <= spurious_count + 8'h01;
    end
`endif
endmodule

// File: tb/tb_timer_irq_master.sv
// tb_timer_irq_master: vector table, hand sequences, live timer model and randomized model check.
module tb_timer_irq_master;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_continuous = 1'b0;
    logic [31:0] cmd_period = '0;
    logic [2:0]  m_address, a2;
    logic        m_chipselect, m_write_n, cs2, wn2;
    logic [15:0] m_writedata, wd2, m_readdata;
    logic        m_irq, busy, tick, busy2, tick2;
    logic [15:0] tick_count;
    logic [3:0]  tc2;
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
    logic [7:0]  spur, spur2;
`endif
    logic        irq_man = 1'b0, live = 1'b0;
    logic [15:0] rd_man = '0, rd_q = '0;
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    timer_irq_master dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .m_address(m_address),
        .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_irq(m_irq), .busy(busy), .tick(tick), .tick_count(tick_count)
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
        , .spurious_count(spur)
`endif
    );

    timer_irq_master #(.TICK_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .m_address(a2),
        .m_chipselect(cs2), .m_write_n(wn2), .m_writedata(wd2),
        .m_readdata(m_readdata), .m_irq(m_irq), .busy(busy2), .tick(tick2), .tick_count(tc2)
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
        , .spurious_count(spur2)
`endif
    );

    // Live interval timer: counts period+1 cycles per timeout, TO cleared by any status write
    logic [31:0] t_per, t_cnt;
    logic        t_run, t_to, t_ito, t_cont;
    assign m_irq      = live ? (t_to & t_ito) : irq_man;
    assign m_readdata = live ? rd_q : rd_man;
    always @(posedge clk) begin
        rd_q <= {14'd0, t_run, t_to};
        if (!live) begin
            t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0; t_per <= '0; t_cnt <= '0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to <= 1'b1; t_cnt <= t_per;
                    if (!t_cont) t_run <= 1'b0;
                end else t_cnt <= t_cnt - 1;
            end
            if (m_chipselect && !m_write_n) begin
                if (m_address == 3'd0) t_to <= 1'b0;
                if (m_address == 3'd2) t_per[15:0] <= m_writedata;
                if (m_address == 3'd3) t_per[31:16] <= m_writedata;
                if (m_address == 3'd1) begin
                    t_ito <= m_writedata[0];
                    if (m_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; t_cont <= m_writedata[1]; end
                    if (m_writedata[3]) t_run <= 1'b0;
                end
            end
        end
    end

    localparam logic [20:0] IDLE_B = {1'b0, 1'b1, 3'd0, 16'd0};
    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction
    function automatic logic [20:0] bus();
        return {m_chipselect, m_write_n, m_address, m_writedata};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; cmd_start = 0; cmd_stop = 0; cmd_continuous = 0; cmd_period = '0;
        irq_man = 0; rd_man = '0; live = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Reference model: the access performed in the coming cycle, taken from a script queue
    localparam int K_NONE = 0, K_CFG = 1, K_CLR = 2, K_STOP = 3;
    logic [20:0] q[$];
    int          cur;
    bit          armed, sp, mcont, last_clr;
    int unsigned mticks;

    task automatic model_init();
        q.delete(); cur = K_NONE; armed = 0; sp = 0; mcont = 0; last_clr = 0; mticks = 0;
    endtask

    task automatic model_step(input bit st, input bit spi, input bit irq, input bit ct,
                              input logic [31:0] per, output logic [20:0] ex, output bit tk);
        bit bz, ign;
        int nk;
        bz = (cur != K_NONE) || armed;
        ign = last_clr;
        nk = K_NONE;
        ex = IDLE_B;
        tk = 0;
        last_clr = (cur == K_CLR);
        if (!bz) begin
            if (st) begin
                mcont = ct;
                q = '{wr(3'd3, per[31:16]), wr(3'd1, ct ? 16'h0007 : 16'h0005)};
                ex = wr(3'd2, per[15:0]);
                nk = K_CFG;
            end
        end else if (cur == K_CFG) begin
            if (q.size() > 0) begin ex = q.pop_front(); nk = K_CFG; end
            else armed = 1;
        end else if (cur == K_CLR || armed) begin
            if (sp) begin ex = wr(3'd1, 16'h0008); nk = K_STOP; armed = 0; end
            else if (cur == K_CLR) armed = mcont;
            else if (irq && !ign) begin ex = wr(3'd0, 16'h0000); tk = 1; nk = K_CLR; mticks++; end
        end
        sp = (nk == K_NONE && !armed) ? 1'b0 : (sp || (spi && bz));
        cur = nk;
    endtask

    typedef struct {
        logic st, sp, irq, ct;
        logic [31:0] per;
        logic [20:0] eb;
        logic tk, by;
    } vec_t;

    function automatic vec_t mk(input logic st, sp, irq, ct, input logic [31:0] per,
                                input logic cs, input logic [2:0] a, input logic [15:0] d,
                                input logic tk, by);
        vec_t v;
        v.st = st; v.sp = sp; v.irq = irq; v.ct = ct; v.per = per;
        v.eb = cs ? wr(a, d) : IDLE_B;
        v.tk = tk; v.by = by;
        return v;
    endfunction

    initial begin
        vec_t        tv[20];
        logic [20:0] ex;
        bit          tk, found;
        int          ts[$];
        int          n;

        tv[0]  = mk(1, 0, 0, 0, 32'h0001_0004, 1, 3'd2, 16'h0004, 0, 1);
        tv[1]  = mk(0, 0, 0, 0, 32'h0,         1, 3'd3, 16'h0001, 0, 1);
        tv[2]  = mk(0, 0, 0, 0, 32'h0,         1, 3'd1, 16'h0005, 0, 1);
        tv[3]  = mk(0, 0, 0, 0, 32'h0,         0, 3'd0, 16'h0000, 0, 1);
        tv[4]  = mk(0, 0, 1, 0, 32'h0,         1, 3'd0, 16'h0000, 1, 1);
        tv[5]  = mk(0, 0, 0, 0, 32'h0,         0, 3'd0, 16'h0000, 0, 0);
        tv[6]  = mk(1, 0, 0, 1, 32'h0000_0123, 1, 3'd2, 16'h0123, 0, 1);
        tv[7]  = mk(0, 0, 0, 0, 32'h0,         1, 3'd3, 16'h0000, 0, 1);
        tv[8]  = mk(0, 0, 0, 0, 32'h0,         1, 3'd1, 16'h0007, 0, 1);
        tv[9]  = mk(0, 0, 0, 0, 32'h0,         0, 3'd0, 16'h0000, 0, 1);
        tv[10] = mk(0, 1, 1, 0, 32'h0,         1, 3'd0, 16'h0000, 1, 1);
        tv[11] = mk(0, 0, 0, 0, 32'h0,         1, 3'd1, 16'h0008, 0, 1);
        tv[12] = mk(0, 0, 0, 0, 32'h0,         0, 3'd0, 16'h0000, 0, 0);
        tv[13] = mk(0, 1, 0, 0, 32'h0,         0, 3'd0, 16'h0000, 0, 0);
        tv[14] = mk(1, 0, 0, 0, 32'h0000_0005, 1, 3'd2, 16'h0005, 0, 1);
        tv[15] = mk(1, 0, 0, 1, 32'hFFFF_FFFF, 1, 3'd3, 16'h0000, 0, 1);
        tv[16] = mk(0, 0, 0, 0, 32'h0,         1, 3'd1, 16'h0005, 0, 1);
        tv[17] = mk(0, 1, 0, 0, 32'h0,         0, 3'd0, 16'h0000, 0, 1);
        tv[18] = mk(0, 0, 0, 0, 32'h0,         1, 3'd1, 16'h0008, 0, 1);
        tv[19] = mk(0, 0, 0, 0, 32'h0,         0, 3'd0, 16'h0000, 0, 0);

        do_reset();
        chk("reset_bus", bus(), IDLE_B);
        chk("reset_busy_tick", {busy, tick, busy2, tick2}, 4'b0000);
        chk("reset_tick_count", {tick_count, tc2}, 20'h0);
`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
        chk("reset_spurious", spur, 8'h00);
`else
        for (int i = 0; i < 20; i++) begin
            cmd_start = tv[i].st; cmd_stop = tv[i].sp; irq_man = tv[i].irq;
            cmd_continuous = tv[i].ct; cmd_period = tv[i].per;
            step();
            chk($sformatf("vec%0d_bus", i), bus(), tv[i].eb);
            chk($sformatf("vec%0d_tick_busy", i), {tick, busy}, {tv[i].tk, tv[i].by});
        end
        cmd_start = 0; cmd_stop = 0; irq_man = 0;
        chk("vec_tick_count", tick_count, 16'd2);

        do_reset();
        model_init();
        for (int c = 0; c < 600; c++) begin
            cmd_start = ($urandom % 6) == 0;
            cmd_stop = ($urandom % 20) == 0;
            irq_man = ($urandom % 5) == 0;
            cmd_continuous = $urandom % 2;
            cmd_period = $urandom;
            model_step(cmd_start, cmd_stop, irq_man, cmd_continuous, cmd_period, ex, tk);
            step();
            chk("rand", {bus(), tick, busy, tick_count},
                {ex, tk, (cur != K_NONE) || armed, mticks[15:0]});
        end
`endif

        do_reset();
        live = 1;
        cmd_start = 1; cmd_continuous = 1; cmd_period = 32'd9;
        step();
        cmd_start = 0;
        for (int c = 1; c <= 55; c++) begin
            step();
            if (tick) ts.push_back(c);
        end
        chk("live_tick_count", ts.size(), 5);
        for (int i = 1; i < ts.size() && i < 5; i++)
            chk($sformatf("live_spacing%0d", i), ts[i] - ts[i-1], 10);
        cmd_stop = 1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            cmd_stop = 0;
            if (bus() == wr(3'd1, 16'h0008)) found = 1;
        end
        chk("live_stop_write", found, 1);
        step();
        chk("live_stop_idle", {bus(), busy}, {IDLE_B, 1'b0});

        do_reset();
        cmd_start = 1; cmd_continuous = 1; cmd_period = '0;
        step();
        cmd_start = 0; irq_man = 1; rd_man = 16'h0001;
        n = 0;
        for (int c = 0; c < 300 && n < 15; c++) begin
            step();
            if (tick) n++;
        end
        chk("wrap_pre", {tc2, tick_count}, {4'hF, 16'd15});
        for (int c = 0; c < 30 && n < 16; c++) begin
            step();
            if (tick) n++;
        end
        chk("wrap_zero", {tc2, tick_count}, {4'h0, 16'd16});

        do_reset();
        cmd_start = 1; cmd_continuous = 0; cmd_period = 32'h1234_5678;
        step();
        cmd_start = 0;
        step();
        chk("midreset_ph", bus(), wr(3'd3, 16'h1234));
        reset_n = 0;
        #1;
        chk("midreset_async", {bus(), busy, tick, tick_count}, {IDLE_B, 1'b0, 1'b0, 16'd0});
        @(posedge clk);
        #1 reset_n = 1;
        step();
        chk("midreset_after", {bus(), busy}, {IDLE_B, 1'b0});

`ifdef TIMER_IRQ_MASTER_STATUS_CHECK_EN
        do_reset();
        cmd_start = 1; cmd_continuous = 1; cmd_period = 32'd100;
        step();
        cmd_start = 0;
        repeat (3) step();
        irq_man = 1; rd_man = 16'h0000;
        step();
        irq_man = 0;
        chk("spur_read", bus(), {1'b1, 1'b1, 3'd0, 16'h0000});
        step();
        step();
        chk("spur_count", {spur, tick, busy, bus()}, {8'd1, 1'b0, 1'b1, IDLE_B});
        irq_man = 1; rd_man = 16'h0001;
        step();
        irq_man = 0;
        chk("to_read", bus(), {1'b1, 1'b1, 3'd0, 16'h0000});
        step();
        step();
        chk("to_clear", {bus(), tick, spur}, {wr(3'd0, 16'h0000), 1'b1, 8'd1});
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/timer_irq_master.md
# timer_irq_master

Avalon-MM master that programs and services the 16-bit-register interval timer peripheral. It runs as a hardware sequencer beside the timer slave in the SPI subsystem. On a start command it writes the period and control registers, then waits for the timer IRQ. At each timeout it clears the status, counts the tick and pulses an event output. This removes the timer's software driver from the CPU.

## Interface
Parameters:
- TICK_W, 16, width of tick_count (wraps modulo 2^TICK_W)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_start  in  1  one-cycle pulse; accepted only in IDLE
- cmd_stop  in  1  one-cycle pulse; accepted in any non-IDLE state
- cmd_period  in  32  timer load value, sampled with cmd_start
- cmd_continuous  in  1  1 = periodic, 0 = one-shot; sampled with cmd_start
- m_address  out  3  timer register select
- m_chipselect  out  1  bus access strobe
- m_write_n  out  1  0 = write access
- m_writedata  out  16  write data
- m_readdata  in  16  timer readdata, registered by the slave (valid the cycle after the read)
- m_irq  in  1  timer interrupt, level
- busy  out  1  state != IDLE
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts since reset
- spurious_count  out  8  IRQs with TO=0; present only with TIMER_IRQ_MASTER_STATUS_CHECK_EN

## Operation
- Timer register map: 0 status {RUN,TO}, where any write clears TO; 1 control {STOP,START,CONT,ITO}; 2 period_l; 3 period_h.
- The slave has no waitrequest, so every access completes in one cycle.
- All bus outputs and tick are registered.
- Each state drives exactly one access. When no access is driven: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- States:
  - IDLE: on cmd_start, latch period and continuous, go to WR_PL.
  - WR_PL: write addr 2 = period[15:0]; go to WR_PH.
  - WR_PH: write addr 3 = period[31:16]; go to WR_CTL.
  - WR_CTL: write addr 1 = 0x5 | (cont<<1), giving 0x5 one-shot or 0x7 continuous; go to ARMED.
  - ARMED: no access.
    - stop_pending set: go to WR_STOP.
    - Else m_irq=1: go to WR_CLR, or to RD_ST with the macro.
  - RD_ST (macro only): read addr 0; go to RD_WAIT.
  - RD_WAIT (macro only): sample m_readdata[0].
    - 1: go to WR_CLR.
    - 0: spurious_count++ (saturating at 0xFF); go to ARMED.
  - WR_CLR: write addr 0 = 0x0000; tick=1; tick_count++ (wraps).
    - stop_pending set: go to WR_STOP.
    - Else continuous: go to ARMED.
    - Else: go to IDLE.
  - WR_STOP: write addr 1 = 0x0008 (STOP, ITO=0); clear stop_pending; go to IDLE.
- cmd_stop outside IDLE sets stop_pending. The stop is acted on at the next ARMED or WR_CLR exit, so an in-flight configure or clear sequence is never split.
- cmd_start while busy is ignored. cmd_stop in IDLE is ignored.
- cmd_stop and m_irq in the same ARMED cycle: the IRQ is serviced first (WR_CLR, tick), then WR_STOP.
- Reset (any state, mid-sequence): state=IDLE, all bus outputs idle as above, busy=0, tick=0, tick_count=0, spurious_count=0, stop_pending=0.

## Timing
- cmd_start sampled at edge E:
  - WR_PL access in cycle E+1, WR_PH in E+2, WR_CTL in E+3.
  - busy=1 from E+1.
- m_irq high in ARMED cycle A:
  - Without macro: WR_CLR write and tick in A+1. The slave drops m_irq from A+2.
  - With macro: read in A+1, decision in A+2, WR_CLR and tick in A+3.
- ARMED ignores m_irq in the cycle immediately after WR_CLR only if it is still high. It cannot be, given the slave's registered clear.
- Continuous service overhead is 1 cycle (3 with the macro). The timer period must be ≥ 4 cycles so that no timeout is missed.

## Configuration
- TIMER_IRQ_MASTER_STATUS_CHECK_EN
  - Defined: RD_ST/RD_WAIT states are added and spurious_count exists. A timeout is counted only when status TO=1.
  - Undefined: every IRQ is treated as a timeout and cleared directly. spurious_count and the read path are removed. m_readdata is unused.

## Test plan
- Reset → all outputs zero except m_write_n=1; tick_count=0; busy=0.
- cmd_start, period 0x0001_0004, continuous=0 → writes (2,0x0004), (3,0x0001), (1,0x0005) on consecutive cycles. Then force m_irq=1 → write (0,0x0000) the next cycle, tick=1, tick_count=1, IDLE.
- Against a live timer model, period 9, continuous=1, run 55 cycles → 5 ticks spaced 10 cycles apart. Then cmd_stop → write (1,0x0008), busy=0.
- cmd_stop and m_irq asserted in the same ARMED cycle → (0,0x0000) then (1,0x0008); tick_count +1.
- Macro on, m_irq=1 with m_readdata=0x0000 → read of addr 0, no clear write, spurious_count=1, back in ARMED. Repeat with m_readdata=0x0001 → clear write, tick.
- Preload tick_count=0xFFFF via 65535 ticks, one more timeout → tick_count=0x0000. Reset asserted during WR_PH → next cycle bus idle, IDLE state.
